// File: rtl/store_pkg.sv
// Shared types for the posted-store buffer.
//   st_sel_e : store size encoding carried on st_sel
//   state_e  : fence-drain FSM states
//   entry_t  : one queued store (word address, lane-aligned data, byte mask)
package store_pkg;

  typedef enum logic [1:0] {
    ST_SB  = 2'b00,
    ST_SH  = 2'b01,
    ST_SW  = 2'b10,
    ST_ILL = 2'b11
  } st_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef struct packed {
    logic [29:0] addr;   // byte address bits [31:2]
    logic [31:0] wdata;
    logic [3:0]  we;
  } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane alignment of a store request.
//   lane       in  2   byte offset st_addr[1:0]
//   data       in  32  unshifted store data
//   sel        in  2   SB/SH/SW/illegal
//   wdata      out 32  data moved onto its byte lanes, unused lanes zero
//   we         out 4   byte write mask
//   misaligned out 1   request cannot be written as a single aligned word access
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [31:0] data,
  input  logic [1:0]  sel,
  output logic [31:0] wdata,
  output logic [3:0]  we,
  output logic        misaligned
);

  always_comb begin
    wdata      = '0;
    we         = '0;
    misaligned = 1'b0;
    case (st_sel_e'(sel))
      ST_SB: begin
        we    = 4'b0001 << lane;
        wdata = {24'h0, data[7:0]} << {lane, 3'b000};
      end
      ST_SH: begin
        if (lane == 2'b00) begin
          we    = 4'b0011;
          wdata = {16'h0, data[15:0]};
        end else if (lane == 2'b10) begin
          we    = 4'b1100;
          wdata = {data[15:0], 16'h0};
        end else begin
          misaligned = 1'b1;
        end
      end
      ST_SW: begin
        if (lane == 2'b00) begin
          we    = 4'b1111;
          wdata = data;
        end else begin
          misaligned = 1'b1;
        end
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer between MEM stage and data memory.
//   st_*        store request in; st_ready combinational, st_misaligned a
//               registered one-cycle reject pulse
//   mem_*       head of the FIFO presented to memory
//   ld_*        load/store word-address hazard check against queued entries
//   fence_*     drain request (level) and one-cycle completion pulse
//   occupancy   number of queued entries
//   dbg_state   current fence FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a valid source holds its payload stable until that edge.
module store_buffer_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_sel,
  output logic             st_misaligned,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_we,
  input  logic [31:0]      ld_check_addr,
  output logic             ld_conflict,
  input  logic             fence_req,
  output logic             fence_done,
  output logic [CNT_W-1:0] occupancy,
  output state_e           dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t            fifo [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  occ_q;
  state_e            state_q, state_d;
  logic              mis_q;

  logic [31:0] al_wdata;
  logic [3:0]  al_we;
  logic        al_mis;
  logic        accept, push, pop, full;
  entry_t      head;

  // Byte lanes of a word address are ignored by the hazard compare.
  logic unused_ld_lane;
  assign unused_ld_lane = ^ld_check_addr[1:0];

  store_lane_align u_align (
    .lane       (st_addr[1:0]),
    .data       (st_data),
    .sel        (st_sel),
    .wdata      (al_wdata),
    .we         (al_we),
    .misaligned (al_mis)
  );

  // No bypass: a full FIFO refuses stores even if the head pops this cycle.
  assign full     = (occ_q == CNT_W'(DEPTH));
  assign st_ready = !full && (state_q == RUN);
  assign accept   = st_valid && st_ready;
  assign push     = accept && !al_mis;
  assign pop      = mem_req_valid && mem_req_ready;

  assign head          = fifo[rd_ptr];
  assign mem_req_valid = (occ_q != '0);
  assign mem_addr      = {head.addr, 2'b00};
  assign mem_wdata     = head.wdata;
  assign mem_we        = head.we;

  assign occupancy     = occ_q;
  assign st_misaligned = mis_q;
  assign fence_done    = (state_q == DONE);
  assign dbg_state     = state_q;

  // Only registered entries count; one popping this cycle is still registered.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (fifo[i].addr == ld_check_addr[31:2])) ld_conflict = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (fence_req) state_d = DRAIN;
      // Leave as soon as the buffer is (or is becoming) empty; no pushes here.
      DRAIN: if (occ_q == '0 || (occ_q == CNT_W'(1) && pop)) state_d = DONE;
      DONE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ_q     <= '0;
      ent_valid <= '0;
      state_q   <= RUN;
      mis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= accept && al_mis;
      if (push) begin
        wr_ptr            <= wr_ptr + PTR_W'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + PTR_W'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Payload storage needs no reset; ent_valid/occupancy qualify it.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{addr: st_addr[31:2], wdata: al_wdata, we: al_we};
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
module tb_store_buffer_ctrl;
  import store_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_sel;
  logic             st_misaligned;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_we;
  logic [31:0]      ld_check_addr;
  logic             ld_conflict;
  logic             fence_req;
  logic             fence_done;
  logic [CNT_W-1:0] occupancy;
  state_e           dbg_state;

  int checks = 0;
  int passes = 0;

  // Model queue entry: {word address[29:0], wdata[31:0], we[3:0]}
  logic [65:0] exp_q[$];

  store_buffer_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_sel(st_sel), .st_misaligned(st_misaligned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ld_check_addr(ld_check_addr), .ld_conflict(ld_conflict),
    .fence_req(fence_req), .fence_done(fence_done),
    .occupancy(occupancy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference alignment built byte by byte: a store of `size` bytes at a
  // size-aligned offset covers bytes [lane, lane+size) taking data bytes 0..size-1.
  function automatic void model_align(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sel, output bit ok,
                                      output logic [31:0] wd, output logic [3:0] we);
    int size;
    int lane;
    size = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    ok   = (sel != 2'd3) && ((lane % size) == 0);
    wd   = '0;
    we   = '0;
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        if (b >= lane && b < lane + size) begin
          we[b]         = 1'b1;
          wd[8*b +: 8]  = d[8*(b-lane) +: 8];
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    st_valid      = 1'b0;
    st_addr       = '0;
    st_data       = '0;
    st_sel        = 2'b00;
    mem_req_ready = 1'b0;
    ld_check_addr = 32'hFFFF_FFF0;
    fence_req     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else passes++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); else passes++;
    checks++; if (st_misaligned !== 1'b0) $display("FAIL reset_mis: got %b want 0", st_misaligned); else passes++;
    checks++; if (fence_done !== 1'b0) $display("FAIL reset_fence_done: got %b want 0", fence_done); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b want 1", st_ready); else passes++;
  endtask

  task automatic test_sb_align();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h0000_1003; st_data = 32'h1234_5678; st_sel = 2'b00;
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL sb_valid: got %b want 1", mem_req_valid); else passes++;
    checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL sb_addr: got %h want 00001000", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'h7800_0000) $display("FAIL sb_wdata: got %h want 78000000", mem_wdata); else passes++;
    checks++; if (mem_we !== 4'b1000) $display("FAIL sb_we: got %b want 1000", mem_we); else passes++;
    checks++; if (occupancy !== 3'd1) $display("FAIL sb_occ: got %0d want 1", occupancy); else passes++;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (occupancy !== 3'd0) $display("FAIL sb_pop_occ: got %0d want 0", occupancy); else passes++;
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs[3];
    logic [1:0]  sels[3];
    addrs = '{32'h0000_2001, 32'h0000_2000, 32'h0000_2002};
    sels  = '{2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = addrs[i]; st_sel = sels[i]; st_data = $urandom;
      @(negedge clk);
      st_valid = 1'b0;
      checks++; if (st_misaligned !== 1'b1) $display("FAIL mis_pulse[%0d]: got %b want 1", i, st_misaligned); else passes++;
      checks++; if (occupancy !== 3'd0) $display("FAIL mis_occ[%0d]: got %0d want 0", i, occupancy); else passes++;
      checks++; if (mem_req_valid !== 1'b0) $display("FAIL mis_valid[%0d]: got %b want 0", i, mem_req_valid); else passes++;
      @(negedge clk);
      checks++; if (st_misaligned !== 1'b0) $display("FAIL mis_clear[%0d]: got %b want 0", i, st_misaligned); else passes++;
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] d[4];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d[i] = $urandom;
      st_valid = 1'b1; st_addr = 32'h4000 + 32'(4*i); st_data = d[i]; st_sel = 2'b10;
    end
    @(negedge clk);
    st_valid = 1'b0;
    checks++; if (st_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", st_ready); else passes++;
    checks++; if (occupancy !== 3'd4) $display("FAIL full_occ: got %0d want 4", occupancy); else passes++;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h4000 || mem_wdata !== d[0]) $display("FAIL hold_head: got %h/%h want 00004000/%h", mem_addr, mem_wdata, d[0]); else passes++;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (st_ready !== 1'b0) $display("FAIL no_bypass: got %b want 0", st_ready); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (occupancy !== 3'(4-i)) $display("FAIL drain_occ[%0d]: got %0d want %0d", i, occupancy, 4-i); else passes++;
      checks++; if (mem_addr !== 32'h4000 + 32'(4*i) || mem_wdata !== d[i] || mem_we !== 4'hF)
        $display("FAIL drain_head[%0d]: got %h/%h/%b want %h/%h/1111", i, mem_addr, mem_wdata, mem_we, 32'h4000 + 32'(4*i), d[i]);
      else passes++;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    checks++; if (occupancy !== 3'd0 || mem_req_valid !== 1'b0) $display("FAIL drain_empty: got occ %0d valid %b want 0/0", occupancy, mem_req_valid); else passes++;
  endtask

  task automatic test_ld_conflict();
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h3000; st_data = $urandom; st_sel = 2'b10;
    ld_check_addr = 32'h3000;
    #1;
    checks++; if (ld_conflict !== 1'b0) $display("FAIL ld_push_same_cycle: got %b want 0", ld_conflict); else passes++;
    @(negedge clk);
    st_valid = 1'b0;
    ld_check_addr = 32'h3002;
    #1;
    checks++; if (ld_conflict !== 1'b1) $display("FAIL ld_hit_lane: got %b want 1", ld_conflict); else passes++;
    ld_check_addr = 32'h3004;
    #1;
    checks++; if (ld_conflict !== 1'b0) $display("FAIL ld_miss_word: got %b want 0", ld_conflict); else passes++;
    ld_check_addr = 32'h3001;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (ld_conflict !== 1'b1) $display("FAIL ld_popping: got %b want 1", ld_conflict); else passes++;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (ld_conflict !== 1'b0) $display("FAIL ld_after_pop: got %b want 0", ld_conflict); else passes++;
    ld_check_addr = 32'hFFFF_FFF0;
  endtask

  task automatic test_fence();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h5000 + 32'(4*i); st_data = $urandom; st_sel = 2'b10;
    end
    @(negedge clk);
    st_valid = 1'b0;
    fence_req = 1'b1;
    @(negedge clk);
    fence_req = 1'b0;
    mem_req_ready = 1'b1;
    checks++; if (st_ready !== 1'b0) $display("FAIL fence_ready_low: got %b want 0", st_ready); else passes++;
    checks++; if (dbg_state !== DRAIN) $display("FAIL fence_state: got %0d want DRAIN", dbg_state); else passes++;
    checks++; if (fence_done !== 1'b0) $display("FAIL fence_early0: got %b want 0", fence_done); else passes++;
    @(negedge clk);
    checks++; if (occupancy !== 3'd1 || fence_done !== 1'b0) $display("FAIL fence_mid: got occ %0d done %b want 1/0", occupancy, fence_done); else passes++;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checks++; if (fence_done !== 1'b1 || occupancy !== 3'd0) $display("FAIL fence_done: got done %b occ %0d want 1/0", fence_done, occupancy); else passes++;
    checks++; if (st_ready !== 1'b0) $display("FAIL fence_done_ready: got %b want 0", st_ready); else passes++;
    @(negedge clk);
    checks++; if (fence_done !== 1'b0 || st_ready !== 1'b1) $display("FAIL fence_after: got done %b ready %b want 0/1", fence_done, st_ready); else passes++;
    // Fence on an empty buffer: done two cycles after the request.
    fence_req = 1'b1;
    @(negedge clk);
    fence_req = 1'b0;
    checks++; if (fence_done !== 1'b0 || st_ready !== 1'b0) $display("FAIL efence_c1: got done %b ready %b want 0/0", fence_done, st_ready); else passes++;
    @(negedge clk);
    checks++; if (fence_done !== 1'b1) $display("FAIL efence_done: got %b want 1", fence_done); else passes++;
    @(negedge clk);
    checks++; if (fence_done !== 1'b0 || st_ready !== 1'b1) $display("FAIL efence_after: got done %b ready %b want 0/1", fence_done, st_ready); else passes++;
  endtask

  task automatic test_random();
    bit          ok;
    logic [31:0] wd;
    logic [3:0]  we;
    bit          exp_ready, exp_conf, mis_exp, mis_next;
    logic [65:0] h;
    mis_exp = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      st_valid      = ($urandom_range(0, 3) != 0);
      st_addr       = 32'h100 + 32'($urandom_range(0, 31));
      st_data       = $urandom;
      st_sel        = 2'($urandom_range(0, 3));
      mem_req_ready = ($urandom_range(0, 2) == 0);
      ld_check_addr = 32'h100 + 32'($urandom_range(0, 31));
      #1;
      exp_ready = (exp_q.size() < DEPTH);
      exp_conf  = 1'b0;
      foreach (exp_q[k]) if (exp_q[k][65:36] == ld_check_addr[31:2]) exp_conf = 1'b1;
      checks++; if (st_ready !== exp_ready) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, st_ready, exp_ready); else passes++;
      checks++; if (occupancy !== 3'(exp_q.size())) $display("FAIL rnd_occ@%0d: got %0d want %0d", cyc, occupancy, exp_q.size()); else passes++;
      checks++; if (ld_conflict !== exp_conf) $display("FAIL rnd_conflict@%0d: got %b want %b", cyc, ld_conflict, exp_conf); else passes++;
      checks++; if (st_misaligned !== mis_exp) $display("FAIL rnd_mis@%0d: got %b want %b", cyc, st_misaligned, mis_exp); else passes++;
      checks++; if (mem_req_valid !== (exp_q.size() != 0)) $display("FAIL rnd_valid@%0d: got %b want %b", cyc, mem_req_valid, exp_q.size() != 0); else passes++;
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        checks++; if ({mem_addr, mem_wdata, mem_we} !== {h[65:36], 2'b00, h[35:4], h[3:0]})
          $display("FAIL rnd_head@%0d: got %h/%h/%b want %h/%h/%b", cyc, mem_addr, mem_wdata, mem_we, {h[65:36], 2'b00}, h[35:4], h[3:0]);
        else passes++;
        if (mem_req_ready) void'(exp_q.pop_front());
      end
      mis_next = 1'b0;
      if (st_valid && exp_ready) begin
        model_align(st_addr, st_data, st_sel, ok, wd, we);
        if (ok) exp_q.push_back({st_addr[31:2], wd, we});
        else mis_next = 1'b1;
      end
      mis_exp = mis_next;
    end
    @(negedge clk);
    idle_inputs();
    mem_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    mem_req_ready = 1'b0;
    exp_q.delete();
    checks++; if (occupancy !== 3'd0) $display("FAIL rnd_final_drain: got %0d want 0", occupancy); else passes++;
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h6000 + 32'(4*i); st_data = $urandom; st_sel = 2'b10;
    end
    @(negedge clk);
    st_valid = 1'b0;
    fence_req = 1'b1;
    @(negedge clk);
    fence_req = 1'b0;
    checks++; if (occupancy !== 3'd3) $display("FAIL rmd_pre_occ: got %0d want 3", occupancy); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL rmd_async_valid: got %b want 0", mem_req_valid); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (occupancy !== 3'd0 || mem_req_valid !== 1'b0) $display("FAIL rmd_after: got occ %0d valid %b want 0/0", occupancy, mem_req_valid); else passes++;
    checks++; if (st_ready !== 1'b1 || fence_done !== 1'b0) $display("FAIL rmd_run: got ready %b done %b want 1/0", st_ready, fence_done); else passes++;
  endtask

  initial begin
    test_reset();
    test_sb_align();
    test_misaligned();
    test_fill_drain();
    test_ld_conflict();
    test_fence();
    test_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
